// File: rtl/tick_period_meter_pkg.sv
// Shared types and default widths for the tick period meter and the clock divider
// that produces the tick.
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } meter_state_t;

    localparam int CNT_W  = 20;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 8;

endpackage

// File: rtl/tick_period_meter_edge.sv
// Rising-edge detector for the tick input. Define TICK_METER_SYNC_EN to place a
// 2-flop synchroniser ahead of the edge flop when tick is asynchronous to CLK.
module edge_rise_detect
    import tick_period_meter_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic tick,
    output logic rise
);

    logic tick_s;
    logic tick_q;

`ifdef TICK_METER_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) sync <= '0;
        else       sync <= {sync[0], tick};
    end

    assign tick_s = sync[1];
`else
    assign tick_s = tick;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) tick_q <= 1'b0;
        else       tick_q <= tick_s;
    end

    // A tick held high yields exactly one edge.
    assign rise = tick_s & ~tick_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures CLK cycles between rising tick edges and recovers the divider setting
// (period >> FRAC_W). Optional input synchroniser: TICK_METER_SYNC_EN.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int CNT_W  = tick_period_meter_pkg::CNT_W,
    parameter int DIV_W  = tick_period_meter_pkg::DIV_W,
    parameter int FRAC_W = tick_period_meter_pkg::FRAC_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             tick,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [DIV_W-1:0] div_est,
    output logic             exact,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    meter_state_t     state, state_nx;
    logic [CNT_W-1:0] count;
    logic             rise;
    logic             prev_ok;   // period register holds a measurement from this run

    edge_rise_detect u_edge (
        .CLK  (CLK),
        .nRST (nRST),
        .tick (tick),
        .rise (rise)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nx = MEASURE;
                MEASURE: if (!rise && count == CNT_MAX) state_nx = STALL;
                STALL:   if (rise) state_nx = MEASURE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count   <= '0;
            period  <= '0;
            div_est <= '0;
            exact   <= 1'b0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
            prev_ok <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clear) begin
                // Measurement outputs are kept; only the run state restarts.
                count   <= '0;
                locked  <= 1'b0;
                timeout <= 1'b0;
                prev_ok <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) count <= CNT_ONE;
                    end
                    MEASURE: begin
                        if (rise) begin
                            period  <= count;
                            div_est <= DIV_W'(count >> FRAC_W);
                            exact   <= (count[FRAC_W-1:0] == '0);
                            valid   <= 1'b1;
                            locked  <= prev_ok && (count == period);
                            prev_ok <= 1'b1;
                            count   <= CNT_ONE;
                        end else if (count == CNT_MAX) begin
                            // Saturate instead of wrapping; the interval is discarded.
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            prev_ok <= 1'b0;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                    STALL: begin
                        if (rise) count <= CNT_ONE;
                    end
                    default: count <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomised bench for tick_period_meter against a timestamp-based reference model.
module tb_tick_period_meter;

    localparam int CW   = 12;
    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          tick = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] period;
    logic [DW-1:0] div_est;
    logic          exact, valid, locked, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: edge timestamps and run flags
    int n = 0;
    int m_last = 0, m_prev = 0, m_period = 0;
    bit m_armed = 0, m_stalled = 0, m_have_prev = 0, m_prev_tick = 0;
    bit m_timeout = 0, m_locked = 0, m_valid = 0;

    always #5 CLK = ~CLK;

    tick_period_meter #(.CNT_W(CW), .DIV_W(DW), .FRAC_W(FW)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .tick    (tick),
        .clear   (clear),
        .period  (period),
        .div_est (div_est),
        .exact   (exact),
        .valid   (valid),
        .locked  (locked),
        .timeout (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_stalled = 0; m_have_prev = 0; m_prev_tick = 0;
        m_timeout = 0; m_locked = 0; m_valid = 0;
    endtask

    task automatic step(input logic t, input logic c);
        bit e;
        int p;
        @(negedge CLK);
        tick  = t;
        clear = c;
        @(posedge CLK);
        #1;
        n++;
        e = t && !m_prev_tick;
        m_prev_tick = t;
        m_valid = 0;
        if (c) begin
            m_armed = 0; m_stalled = 0; m_timeout = 0; m_locked = 0; m_have_prev = 0;
        end else if (e) begin
            if (m_armed && !m_stalled) begin
                p = n - m_last;
                m_valid = 1;
                m_period = p;
                m_locked = m_have_prev && (p == m_prev);
                m_have_prev = 1;
                m_prev = p;
            end else begin
                m_armed = 1; m_stalled = 0; m_have_prev = 0;
            end
            m_last = n;
        end else if (m_armed && !m_stalled && (n - m_last) == MAXC) begin
            m_stalled = 1; m_timeout = 1; m_locked = 0; m_have_prev = 0;
        end
        chk("valid", 32'(valid), 32'(m_valid));
        chk("timeout", 32'(timeout), 32'(m_timeout));
        chk("locked", 32'(locked), 32'(m_locked));
        if (m_valid) begin
            chk("period", 32'(period), 32'(m_period));
            chk("div_est", 32'(div_est), 32'((m_period / 256) % 65536));
            chk("exact", 32'(exact), 32'((m_period % 256) == 0));
        end
    endtask

    // one tick pulse of width w, next edge gap cycles later
    task automatic pulse(input int w, input int gap);
        for (int i = 0; i < w; i++) step(1'b1, 1'b0);
        for (int i = w; i < gap; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        int g, prev_g, v;
        #12;
        chk("rst_period", 32'(period), 0);
        chk("rst_div", 32'(div_est), 0);
        chk("rst_flags", {28'd0, exact, valid, locked, timeout}, 0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // divider div=2: 512-cycle spacing
        for (int i = 0; i < 5; i++) pulse($urandom_range(1, 3), 512);
        // 300-cycle spacing
        for (int i = 0; i < 4; i++) pulse(1, 300);
        // 512 then 768
        for (int i = 0; i < 3; i++) pulse(1, 512);
        for (int i = 0; i < 3; i++) pulse(2, 768);

        // random spacings, some repeated to exercise lock
        prev_g = 100;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 2);
            if (v == 0)      g = prev_g;
            else if (v == 1) g = 256 * $urandom_range(1, 4);
            else             g = $urandom_range(4, 1100);
            pulse($urandom_range(1, 3), g);
            prev_g = g;
        end

        // longest measurable interval, no timeout
        for (int i = 0; i < 3; i++) pulse(1, MAXC);

        // stall, resume, then clear
        step(1'b0, 1'b1);
        pulse(1, MAXC + 100);
        pulse(1, 600);
        pulse(1, 600);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        // clear with simultaneous edge, tick held high 10 cycles
        pulse(1, 400);
        step(1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1, 400);

        // reset mid-measurement
        pulse(1, 200);
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_period", 32'(period), 0);
        chk("mid_rst_div", 32'(div_est), 0);
        chk("mid_rst_flags", {28'd0, exact, valid, locked, timeout}, 0);
        model_reset();
        tick = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) pulse(1, 350);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Measures the spacing, in CLK cycles, between rising edges of a tick input, and recovers the divider setting that produced it.
- Acts as the receive end of the divided-clock tick: a divider setting `div` emits a 1-cycle pulse every `div<<8` cycles; this block recovers the period and `div`.
- Used by the clock/debug path to confirm the CPU clock rate and to flag a stalled clock.

Parameters:
- CNT_W, 20: width of the period counter and of the `period` output.
- DIV_W, 16: width of the `div_est` output.
- FRAC_W, 8: shift between period and divider setting; the divider period is `div<<FRAC_W`.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- nRST  in  1  asynchronous active-low reset.
- tick  in  1  measured tick; rising edge marks a period boundary.
- clear  in  1  synchronous restart; returns to IDLE and clears `locked` and `timeout`.
- period  out  CNT_W  last measured edge-to-edge distance in CLK cycles.
- div_est  out  DIV_W  period >> FRAC_W, zero-extended or truncated to DIV_W.
- exact  out  1  period[FRAC_W-1:0] == 0 for the held measurement.
- valid  out  1  1-cycle pulse when period/div_est/exact update.
- locked  out  1  the last two measurements were equal.
- timeout  out  1  no edge arrived within 2^CNT_W-1 cycles; sticky.

Behaviour:
- Reset: state=IDLE, count=0, period=0, div_est=0, exact=0, valid=0, locked=0, timeout=0, edge-detect flop=0.
- Edge detect: tick_s is tick (or its synchronised version, see Optional Feature). tick_q <= tick_s. edge = tick_s & ~tick_q. A tick held high produces one edge only.
- States: IDLE, MEASURE, STALL.
  - IDLE: on edge, count <= 1 and go to MEASURE. No valid pulse is produced for the first edge.
  - MEASURE, edge: period <= count and count <= 1. div_est and exact are derived from the same count. valid <= 1 in the next cycle only.
  - MEASURE, no edge and count == 2^CNT_W-1: go to STALL, timeout <= 1, locked <= 0.
  - MEASURE, otherwise: count <= count+1.
  - STALL: count holds. On edge, count <= 1 and go to MEASURE. timeout stays 1. No valid pulse for the interval that timed out.
- Counting convention: edges at cycles t and t+P give period=P. Registered outputs update at t+P+1 (edge-sampled) with valid high for exactly that cycle.
- Lock: on each valid update, locked <= (new period == previous period). The first measurement after IDLE or STALL always gives locked=0.
- clear has priority over everything, including an edge in the same cycle: state=IDLE, count=0, locked=0, timeout=0. period/div_est/exact hold their values; valid=0.
- Arithmetic: count never wraps; it saturates into STALL. All comparisons are unsigned, CNT_W bits.
- Reset asserted mid-measurement: immediate return to all reset values. The partial interval is discarded.

Optional Feature:
- Macro: TICK_METER_SYNC_EN.
- Defined: tick passes through a 2-flop synchroniser (reset 0) before edge detect. Output latency grows by 2 cycles; measured periods are unchanged.
- Undefined: tick is assumed synchronous to CLK and feeds edge detect directly.

Decomposition:
- Shared package: meter_state_t enum {IDLE, MEASURE, STALL} and the constants CNT_W, DIV_W, FRAC_W (shared with the clock divider's count width).
- One natural sub-module, `edge_rise_detect`: optional synchroniser plus rising-edge flop, outputting `edge`.
- Counter, FSM and output registers stay in the top module.

Test Plan:
- Drive tick from a divider with div=2, running 4 periods -> valid pulses 512 cycles apart; period=512, div_est=2, exact=1; locked=0 on the first pulse, 1 from the second pulse on.
- Synchronous pulses 300 cycles apart -> period=300, div_est=1, exact=0; locked=1 after the second measurement.
- Change the spacing from 512 to 768 mid-run -> the first 768 measurement gives locked=0 and div_est=3; the next gives locked=1.
- Stop tick after one edge -> timeout=1 after 2^20-1 counted cycles, locked=0, no valid. A resumed edge re-enters MEASURE and the next interval reports correctly with timeout still 1; clear then sets timeout=0.
- Assert clear in the same cycle as an edge, and hold tick high for 10 cycles -> clear wins (IDLE, no valid); a held-high tick produces a single edge.
- Pulse nRST low mid-measurement -> all outputs 0 immediately; the next measurement needs two fresh edges.
